// File: rtl/stream_bit_packer.sv
// Bit-to-word packer: collects WIDTH bits in arrival order and emits them as one
// word built with either {>>{...}} or {<<SLICE{...}} streaming, left-justified.
module stream_bit_packer #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1,
  parameter int NBW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  input  logic             stream_left,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [NBW-1:0]   out_nbits,
  output logic             out_last
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [NBW-1:0]   count, count_next;
  logic             mode, mode_next;
  logic             hold_last, hold_last_next;
  logic             accept, out_free;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic [NBW-1:0]   load_nbits;
  logic             load_last;

  // acc[k] holds stream bit b_k; bits at or above n are zero. Result is n bits wide,
  // placed at the MSB end of the word.
  function automatic logic [WIDTH-1:0] pack(input logic [WIDTH-1:0] bits,
                                            input int n, input logic left);
    logic [WIDTH-1:0] res;
    int i, j, o, rpos;
    res = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k < n) begin
        if (!left) begin
          res[WIDTH-1-k] = bits[k];
        end else begin
          // b_k sits at S[i]; slice j of S lands j slices down from the top, and a
          // short leftmost slice of S lands in the lowest positions of the result.
          i    = n - 1 - k;
          j    = i / SLICE;
          o    = i % SLICE;
          rpos = ((j + 1) * SLICE <= n) ? (n - (j + 1) * SLICE + o) : o;
          res[WIDTH-n+rpos] = bits[k];
        end
      end
    end
    return res;
  endfunction

  assign in_ready = rst_n && (state == FILL);
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_next     = state;
    acc_next       = acc;
    count_next     = count;
    mode_next      = mode;
    hold_last_next = hold_last;
    load           = 1'b0;
    load_data      = pack(acc, int'(count), mode);
    load_nbits     = count;
    load_last      = hold_last;

    case (state)
      FILL: begin
        if (accept) begin
          if (count == '0) begin
            acc_next  = '0;
            mode_next = stream_left;
          end
          for (int k = 0; k < WIDTH; k++) begin
            if (k == int'(count)) acc_next[k] = in_bit;
          end
          count_next = count + 1'b1;
          if (count_next == NBW'(WIDTH) || in_last) begin
            load_data      = pack(acc_next, int'(count_next), mode_next);
            load_nbits     = count_next;
            load_last      = in_last;
            hold_last_next = in_last;
            if (out_free) begin
              load       = 1'b1;
              count_next = '0;
            end else begin
              state_next = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          load       = 1'b1;
          count_next = '0;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  // NOTE: the accumulator is reset too; it is a handful of flops, and clearing it
  // guarantees no pre-reset bits can leak into the first word after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      count     <= '0;
      mode      <= 1'b0;
      hold_last <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nbits <= '0;
      out_last  <= 1'b0;
    end else begin
      acc       <= acc_next;
      count     <= count_next;
      mode      <= mode_next;
      hold_last <= hold_last_next;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_nbits <= load_nbits;
        out_last  <= load_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_bit_packer.sv
// Directed bench: three builds (8/1, 8/2, 4/1) share one input stream; each output
// is compared against hand-computed words.
module tb_stream_bit_packer;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_bit, in_last, stream_left, out_ready;

  logic       a_in_ready, a_out_valid, a_out_last;
  logic [7:0] a_out_data;
  logic [3:0] a_out_nbits;
  logic       b_in_ready, b_out_valid, b_out_last;
  logic [7:0] b_out_data;
  logic [3:0] b_out_nbits;
  logic       c_in_ready, c_out_valid, c_out_last;
  logic [3:0] c_out_data;
  logic [2:0] c_out_nbits;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_bit_packer #(.WIDTH(8), .SLICE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_bit(in_bit), .in_last(in_last), .stream_left(stream_left),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_nbits(a_out_nbits), .out_last(a_out_last));

  stream_bit_packer #(.WIDTH(8), .SLICE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_bit(in_bit), .in_last(in_last), .stream_left(stream_left),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_nbits(b_out_nbits), .out_last(b_out_last));

  stream_bit_packer #(.WIDTH(4), .SLICE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_bit(in_bit), .in_last(in_last), .stream_left(stream_left),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .out_nbits(c_out_nbits), .out_last(c_out_last));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic last, input logic left);
    in_valid    = 1'b1;
    in_bit      = b;
    in_last     = last;
    stream_left = left;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
  endtask

  logic [7:0] w;
  logic [7:0] w2;
  int         words;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
    stream_left = 1'b0; out_ready = 1'b1;

    #1;
    check("reset in_ready", a_in_ready, 0);
    check("reset out_valid", a_out_valid, 0);
    check("reset out_data", a_out_data, 0);
    check("reset out_nbits", a_out_nbits, 0);
    check("reset out_last", a_out_last, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("in_ready after release", a_in_ready, 1);
    step();

    // >> mode, with an idle gap mid-word that must not flush anything
    w = 8'hd2;
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i], 1'b0, 1'b0);
      if (i == 2) begin
        repeat (4) idle();
        check("idle keeps partial", a_out_valid, 0);
      end
      if (i == 3) check("w4 >> d", {c_out_valid, c_out_nbits, c_out_data}, {1'b1, 3'd4, 4'hd});
      if (i == 6) check("w8 not early", a_out_valid, 0);
    end
    check("w8 >> d2", {a_out_valid, a_out_nbits, a_out_last, a_out_data}, {1'b1, 4'd8, 1'b0, 8'hd2});
    check("w8s2 >> d2", b_out_data, 8'hd2);
    check("w4 >> 2", c_out_data, 4'h2);
    idle();
    check("word consumed", a_out_valid, 0);

    // << mode; stream_left only on the first bit, later changes must be ignored
    for (int i = 0; i < 8; i++) begin
      send_bit(w[7-i], 1'b0, (i == 0));
      if (i == 3) check("w4 << b", c_out_data, 4'hb);
    end
    check("w8 << 4b", {a_out_valid, a_out_nbits, a_out_data}, {1'b1, 4'd8, 8'h4b});
    check("w8s2 << 87", b_out_data, 8'h87);
    check("w4 mode relatched >> 2", c_out_data, 4'h2);
    idle();

    // partial words closed by in_last
    send_bit(1'b1, 1'b0, 1'b0); send_bit(1'b1, 1'b0, 1'b0); send_bit(1'b0, 1'b1, 1'b0);
    check("partial >> w8", {a_out_valid, a_out_nbits, a_out_last, a_out_data}, {1'b1, 4'd3, 1'b1, 8'hc0});
    check("partial >> w8s2", b_out_data, 8'hc0);
    check("partial >> w4", {c_out_nbits, c_out_last, c_out_data}, {3'd3, 1'b1, 4'hc});
    idle();
    send_bit(1'b1, 1'b0, 1'b1); send_bit(1'b1, 1'b0, 1'b1); send_bit(1'b0, 1'b1, 1'b1);
    check("partial << w8", {a_out_valid, a_out_nbits, a_out_last, a_out_data}, {1'b1, 4'd3, 1'b1, 8'h60});
    check("partial << w8s2 short slice", b_out_data, 8'ha0);
    check("partial << w4", {c_out_nbits, c_out_data}, {3'd3, 4'h6});
    idle();

    // in_last on the bit that fills the word
    w = 8'h96;
    for (int i = 0; i < 8; i++) send_bit(w[7-i], (i == 7), 1'b0);
    check("full+last", {a_out_valid, a_out_nbits, a_out_last, a_out_data}, {1'b1, 4'd8, 1'b1, 8'h96});
    idle();

    // backpressure: two words with the consumer stalled
    out_ready = 1'b0;
    w  = 8'ha5;
    w2 = 8'h3c;
    for (int i = 0; i < 8; i++) send_bit(w[7-i], 1'b0, 1'b0);
    check("bp first word", {a_out_valid, a_out_data}, {1'b1, 8'ha5});
    for (int i = 0; i < 8; i++) begin
      check("bp in_ready while filling", a_in_ready, 1);
      send_bit(w2[7-i], 1'b0, 1'b0);
      if (i == 3) check("bp held mid", a_out_data, 8'ha5);
    end
    in_valid = 1'b0;
    check("bp hold in_ready", a_in_ready, 0);
    check("bp held after 16", {a_out_valid, a_out_nbits, a_out_data}, {1'b1, 4'd8, 8'ha5});
    step();
    check("bp still held", {a_in_ready, a_out_data}, {1'b0, 8'ha5});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp second word", {a_out_valid, a_out_nbits, a_out_data}, {1'b1, 4'd8, 8'h3c});
    check("bp in_ready back", a_in_ready, 1);
    step();
    check("bp second held", {a_out_valid, a_out_data}, {1'b1, 8'h3c});
    out_ready = 1'b1;
    step();
    check("bp drained", a_out_valid, 0);

    // reset mid-word discards everything
    out_ready = 1'b0;
    w = 8'ha8;
    for (int i = 0; i < 5; i++) send_bit(w[7-i], 1'b0, 1'b0);
    check("pre-reset w4 word", {c_out_valid, c_out_data}, {1'b1, 4'ha});
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid reset w4 valid", c_out_valid, 0);
    check("mid reset w4 data", c_out_data, 0);
    check("mid reset w8 in_ready", a_in_ready, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    words = 0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, 1'b0, 1'b0);
      if (a_out_valid) words++;
      if (i == 7) check("post reset ff", {a_out_nbits, a_out_last, a_out_data}, {4'd8, 1'b0, 8'hff});
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      if (a_out_valid) words++;
    end
    check("post reset word count", words, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
